// File: rtl/data_mem_access_unit_if.sv
// Request/response and data-RAM bus bundle for data_mem_access_unit.
// Latency: none, plain wires.
// Backpressure: o_busy from the unit stalls the requester; the RAM side has no backpressure.
interface data_mem_access_unit_if #(
  parameter int ADDR_WIDTH = 8
);
  // pipeline request side
  logic                  i_req;
  logic                  i_we;
  logic [1:0]            i_size;
  logic [31:0]           i_addr;
  logic [31:0]           i_wdata;
  // pipeline response side
  logic                  o_busy;
  logic                  o_done;
  logic                  o_misaligned;
  logic [1:0]            o_byte_offset;
  logic [31:0]           o_selected_data;
  // data RAM side
  logic                  o_mem_en;
  logic                  o_mem_we;
  logic [3:0]            o_mem_be;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic [31:0]           i_mem_rdata;

  // the access unit itself
  modport slave (
    input  i_req, i_we, i_size, i_addr, i_wdata, i_mem_rdata,
    output o_busy, o_done, o_misaligned, o_byte_offset, o_selected_data,
           o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
  );

  // the pipeline plus RAM surrounding the unit
  modport master (
    output i_req, i_we, i_size, i_addr, i_wdata, i_mem_rdata,
    input  o_busy, o_done, o_misaligned, o_byte_offset, o_selected_data,
           o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Multi-cycle byte/half/word load/store controller between the MEM stage and the data RAM.
// Latency to o_done: misaligned 1 cycle, store 2 cycles, load 1+MEM_LATENCY cycles.
// Backpressure: o_busy is high outside IDLE; i_req is ignored until the unit is back in IDLE.
module data_mem_access_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  data_mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;

  logic                  req_we;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  req_mis;
  logic [1:0]            byte_offset;
  logic [31:0]           selected_data;

  logic                  misaligned_in;
  logic                  accept;
  logic                  capture;

  // address bits above the RAM word range are deliberately dropped
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^bus.i_addr[31:ADDR_WIDTH+2];

  assign bus.o_byte_offset   = byte_offset;
  assign bus.o_selected_data = selected_data;

  // classify the incoming request's alignment against its access size
  always_comb begin
    misaligned_in = 1'b0;
    case (bus.i_size)
      2'b00:   misaligned_in = 1'b0;
      2'b01:   misaligned_in = bus.i_addr[0];
      2'b10:   misaligned_in = |bus.i_addr[1:0];
      default: misaligned_in = 1'b1;
    endcase
  end

  // state and latency counter register; reset drops any in-flight request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // request capture at accept and load-data capture at the edge entering RESP
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_we        <= 1'b0;
      req_size      <= 2'b00;
      req_addr      <= '0;
      req_wdata     <= 32'h0;
      req_mis       <= 1'b0;
      byte_offset   <= 2'b00;
      selected_data <= 32'h0;
    end else begin
      if (accept) begin
        req_we      <= bus.i_we;
        req_size    <= bus.i_size;
        req_addr    <= bus.i_addr[ADDR_WIDTH+1:0];
        req_wdata   <= bus.i_wdata;
        req_mis     <= misaligned_in;
        byte_offset <= bus.i_addr[1:0];
      end
      if (capture) begin
        selected_data <= bus.i_mem_rdata;
      end
    end
  end

  // next-state logic plus RAM strobes and response outputs decoded from state
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    accept           = 1'b0;
    capture          = 1'b0;
    bus.o_busy       = (state != S_IDLE);
    bus.o_done       = 1'b0;
    bus.o_misaligned = 1'b0;
    bus.o_mem_en     = 1'b0;
    bus.o_mem_we     = 1'b0;
    bus.o_mem_be     = 4'b0000;
    bus.o_mem_addr   = '0;
    bus.o_mem_wdata  = 32'h0;

    case (state)
      S_IDLE: begin
        if (bus.i_req) begin
          accept    = 1'b1;
          state_nxt = misaligned_in ? S_RESP : S_ACCESS;
        end
      end

      S_ACCESS: begin
        bus.o_mem_en   = 1'b1;
        bus.o_mem_we   = req_we;
        bus.o_mem_addr = req_addr[ADDR_WIDTH+1:2];
        if (req_we) begin
          // lane-replicate store data so the byte enables pick the right lanes
          case (req_size)
            2'b00: begin
              bus.o_mem_be    = 4'b0001 << req_addr[1:0];
              bus.o_mem_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
              bus.o_mem_be    = 4'b0011 << req_addr[1:0];
              bus.o_mem_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
              bus.o_mem_be    = 4'b1111;
              bus.o_mem_wdata = req_wdata;
            end
          endcase
          state_nxt = S_RESP;
        end else begin
          bus.o_mem_be = 4'b1111;
          if (MEM_LATENCY == 1) begin
            state_nxt = S_RESP;
            capture   = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 3'(MEM_LATENCY - 1);
          end
        end
      end

      S_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nxt = S_RESP;
          capture   = 1'b1;
        end
      end

      S_RESP: begin
        bus.o_done       = 1'b1;
        bus.o_misaligned = req_mis;
        state_nxt        = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with one MEM_LATENCY=1 and one MEM_LATENCY=3 instance.
// Read data reaches the unit at the MEM_LATENCY-th rising edge counted from the start of the access cycle.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_data_mem_access_unit;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_mem_access_unit_if #(.ADDR_WIDTH(AW)) b1 ();
  data_mem_access_unit_if #(.ADDR_WIDTH(AW)) b3 ();

  data_mem_access_unit #(.ADDR_WIDTH(AW), .MEM_LATENCY(1)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b1.slave)
  );

  data_mem_access_unit #(.ADDR_WIDTH(AW), .MEM_LATENCY(3)) u_dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b3.slave)
  );

  // RAM models: word 1 preloaded with 0x80FF7F01 while reset is held
  logic [31:0] ram1 [0:255];
  logic [31:0] ram3 [0:255];
  logic [31:0] r3_p1 = 32'h0;
  logic [31:0] r3_p2 = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram1[i] = 32'h0;
      ram1[1] = 32'h80FF7F01;
    end else if (b1.o_mem_en && b1.o_mem_we) begin
      for (int n = 0; n < 4; n++)
        if (b1.o_mem_be[n]) ram1[b1.o_mem_addr][8*n +: 8] = b1.o_mem_wdata[8*n +: 8];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram3[i] = 32'h0;
      ram3[1] = 32'h80FF7F01;
    end else if (b3.o_mem_en && b3.o_mem_we) begin
      for (int n = 0; n < 4; n++)
        if (b3.o_mem_be[n]) ram3[b3.o_mem_addr][8*n +: 8] = b3.o_mem_wdata[8*n +: 8];
    end
  end

  assign b1.i_mem_rdata = (b1.o_mem_en && !b1.o_mem_we) ? ram1[b1.o_mem_addr] : 32'h0;

  always @(posedge clk) begin
    r3_p1 <= (b3.o_mem_en && !b3.o_mem_we) ? ram3[b3.o_mem_addr] : 32'h0;
    r3_p2 <= r3_p1;
  end
  assign b3.i_mem_rdata = r3_p2;

  // strobe counters, each written only here
  int en_cnt1   = 0;
  int en_cnt3   = 0;
  int done_cnt3 = 0;
  always @(negedge clk) begin
    en_cnt1   <= en_cnt1 + (b1.o_mem_en ? 1 : 0);
    en_cnt3   <= en_cnt3 + (b3.o_mem_en ? 1 : 0);
    done_cnt3 <= done_cnt3 + (b3.o_done ? 1 : 0);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic req, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      b3.i_req = req; b3.i_we = we; b3.i_size = size; b3.i_addr = addr; b3.i_wdata = wdata;
    end else begin
      b1.i_req = req; b1.i_we = we; b1.i_size = size; b1.i_addr = addr; b1.i_wdata = wdata;
    end
  endtask

  // steps until o_done is seen, counting cycles from the first post-accept sample
  task automatic wait_done(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? b3.o_done : b1.o_done) && lat < 12) begin
      step();
      lat++;
    end
  endtask

  logic [1:0]  mis_size [3] = '{2'b01, 2'b10, 2'b11};
  logic [31:0] mis_addr [3] = '{32'h3, 32'h2, 32'h0};

  initial begin
    int          lat;
    int          e0;
    int          d0;
    int          en_before;
    logic [31:0] shifted;
    logic [31:0] sext;

    rst = 1'b1;
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
    step();
    step();

    // reset state
    chk("rst_busy",     b1.o_busy, 0);
    chk("rst_done",     b1.o_done, 0);
    chk("rst_mis",      b1.o_misaligned, 0);
    chk("rst_off",      b1.o_byte_offset, 0);
    chk("rst_sel",      b1.o_selected_data, 0);
    chk("rst_en",       b1.o_mem_en, 0);
    chk("rst_be",       b1.o_mem_be, 0);
    chk("rst_maddr",    b1.o_mem_addr, 0);
    chk("rst_wdata",    b1.o_mem_wdata, 0);
    chk("rst_busy3",    b3.o_busy, 0);
    rst = 1'b0;
    step();

    // lw addr 0x4, latency 1
    drive(0, 1, 0, 2'b10, 32'h4, 32'h0);
    step();
    drive(0, 0, 0, 2'b10, 32'h4, 32'h0);
    chk("lw_en",    b1.o_mem_en, 1);
    chk("lw_we",    b1.o_mem_we, 0);
    chk("lw_maddr", b1.o_mem_addr, 1);
    chk("lw_be",    b1.o_mem_be, 4'b1111);
    chk("lw_busy",  b1.o_busy, 1);
    wait_done(0, lat);
    chk("lw_lat",   lat, 1);
    chk("lw_data",  b1.o_selected_data, 32'h80FF7F01);
    chk("lw_off",   b1.o_byte_offset, 2'b00);
    chk("lw_mis",   b1.o_misaligned, 0);
    step();
    chk("lw_idle",  b1.o_busy, 0);

    // lb addr 0x7, latency 3
    drive(1, 1, 0, 2'b00, 32'h7, 32'h0);
    step();
    drive(1, 0, 0, 2'b00, 32'h7, 32'h0);
    chk("lb_en",    b3.o_mem_en, 1);
    wait_done(1, lat);
    chk("lb_lat",   lat, 3);
    chk("lb_data",  b3.o_selected_data, 32'h80FF7F01);
    chk("lb_off",   b3.o_byte_offset, 2'b11);
    shifted = b3.o_selected_data >> (8 * b3.o_byte_offset);
    sext    = {{24{shifted[7]}}, shifted[7:0]};
    chk("lb_sext",  sext, 32'hFFFFFF80);
    step();

    // sb addr 0x6 data 0xA5
    drive(0, 1, 1, 2'b00, 32'h6, 32'h000000A5);
    step();
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    chk("sb_en",    b1.o_mem_en, 1);
    chk("sb_we",    b1.o_mem_we, 1);
    chk("sb_maddr", b1.o_mem_addr, 1);
    chk("sb_be",    b1.o_mem_be, 4'b0100);
    chk("sb_wdata", b1.o_mem_wdata, 32'hA5A5A5A5);
    wait_done(0, lat);
    chk("sb_lat",   lat, 1);
    chk("sb_mis",   b1.o_misaligned, 0);
    chk("sb_off",   b1.o_byte_offset, 2'b10);
    chk("sb_sel",   b1.o_selected_data, 32'h80FF7F01);
    step();
    chk("sb_ram",   ram1[1], 32'h80A57F01);

    // misaligned: lh 0x3, lw 0x2, illegal size
    en_before = en_cnt1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, mis_size[k], mis_addr[k], 32'h0);
      step();
      drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
      wait_done(0, lat);
      chk($sformatf("mis%0d_lat", k), lat, 0);
      chk($sformatf("mis%0d_flag", k), b1.o_misaligned, 1);
      chk($sformatf("mis%0d_sel", k), b1.o_selected_data, 32'h80FF7F01);
      chk($sformatf("mis%0d_off", k), b1.o_byte_offset, {30'h0, mis_addr[k][1:0]});
      step();
    end
    chk("mis_no_en", en_cnt1 - en_before, 0);

    // held request: sh 0x2 then sw 0x8
    drive(0, 1, 1, 2'b01, 32'h2, 32'h00001234);
    step();
    chk("sh_be",    b1.o_mem_be, 4'b1100);
    chk("sh_wdata", b1.o_mem_wdata, 32'h12341234);
    chk("sh_maddr", b1.o_mem_addr, 0);
    step();
    chk("sh_done",  b1.o_done, 1);
    drive(0, 1, 1, 2'b10, 32'h8, 32'hDEADBEEF);
    step();
    chk("held_idle", b1.o_busy, 0);
    step();
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    chk("sw_en",    b1.o_mem_en, 1);
    chk("sw_maddr", b1.o_mem_addr, 2);
    chk("sw_be",    b1.o_mem_be, 4'b1111);
    chk("sw_wdata", b1.o_mem_wdata, 32'hDEADBEEF);
    wait_done(0, lat);
    chk("sw_lat",   lat, 1);
    step();
    chk("sh_ram",   ram1[0], 32'h12340000);
    chk("sw_ram",   ram1[2], 32'hDEADBEEF);

    // reset while the latency-3 load sits in WAIT
    drive(1, 1, 0, 2'b10, 32'h4, 32'h0);
    step();
    drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
    step();
    chk("mid_busy",  b3.o_busy, 1);
    chk("mid_ndone", b3.o_done, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", b3.o_busy, 0);
    chk("mid_rst_sel",  b3.o_selected_data, 0);
    chk("mid_rst_en",   b3.o_mem_en, 0);
    e0 = en_cnt3;
    d0 = done_cnt3;
    repeat (6) step();
    chk("mid_no_en",   en_cnt3 - e0, 0);
    chk("mid_no_done", done_cnt3 - d0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
